spi_master_txn: RTL and testbench
=================================

Name: spi_master_txn

Overview:
- SPI initiator that drives the transactions consumed by the slave-side control FSM: chip select, serial clock, address + R/W command byte, then one data byte.
- Sits between a host-side request interface (start/addr/rw/wdata) and the four SPI pins.
- Used as the bench/host driver for the SPI memory block and as the on-chip master for loopback builds.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (legal values >= 1)
ADDR_WIDTH, 7, address bits sent before the R/W bit (ADDR_WIDTH + 1 = 8)
DATA_WIDTH, 8, data bits per transaction

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when busy=0
rw  input  1  1 = read, 0 = write; latched with start
addr  input  ADDR_WIDTH  target address; latched with start
wdata  input  DATA_WIDTH  write data; latched with start
busy  output  1  high from the accepting edge through the done cycle
done  output  1  one-cycle completion pulse
rdata  output  DATA_WIDTH  last read byte; held until the next read completes
sclk  output  1  serial clock, idle low
cs  output  1  chip select, active low, idle high
mosi  output  1  master-out data, MSB first
miso  input  1  slave-out data; slave updates it after the SCLK falling edge

Behaviour:
- Reset (synchronous, priority over everything): cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE, counters cleared. Applies mid-transaction; cs rises at the next edge and no further SCLK edges are produced.
- Frame: 16 bits, MSB first.
  - Bits 0..6: addr[6:0].
  - Bit 7: rw.
  - Bits 8..15: wdata[7:0] for a write, 0 for a read.
- States: IDLE -> LEAD -> HIGH <-> LOW (16 bit periods) -> GAP -> DONE -> IDLE.
- IDLE: cs=1, sclk=0, busy=0. At edge T, start=1 latches rw/addr/wdata, sets cs=0, busy=1, mosi=addr MSB, and moves to LEAD.
- LEAD: CLK_DIV cycles with sclk=0 and cs=0 (setup before the first rising edge).
- HIGH: sclk=1 for CLK_DIV cycles; mosi stable.
  - For a read, at the edge that ends HIGH for bits 8..15, shift miso into an internal shift register.
- LOW: sclk=0 for CLK_DIV cycles.
  - mosi changes to the next bit at the edge that enters LOW, i.e. on the SCLK falling edge.
  - After bit 15's LOW phase, go to GAP.
- GAP: cs=1, sclk=0, mosi=0 for CLK_DIV cycles.
- DONE: one cycle with done=1 and busy=1.
  - A read copies the shift register to rdata on the edge entering DONE.
  - A write leaves rdata unchanged.
  - Next edge returns to IDLE with busy=0.
- Timing: exactly 16 SCLK rising edges while cs=0. done is high in the cycle after edge T + 34*CLK_DIV + 1 (LEAD + 32 half-periods + GAP + 1). The SCLK period is 2*CLK_DIV clk cycles.
- start while busy=1 is ignored and not queued. start held high continuously gives back-to-back transactions: the next one is accepted on the first IDLE edge, so cs is high for at least CLK_DIV+2 cycles between frames.
- sclk never glitches: it is a registered output, and cs changes only while sclk=0.
- The half-period counter is wide enough for CLK_DIV-1 and wraps to 0 at each phase change. The bit counter covers 0..15.

Test Plan:
- Reset: hold reset for 3 cycles mid-idle -> cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00.
- Write, CLK_DIV=4, addr=7'h55, rw=0, wdata=8'hA3 -> MOSI captured on SCLK rising edges = 1010101 0 10100011; exactly 16 rising edges with cs=0; done one cycle at edge T+137; rdata unchanged.
- Read, addr=7'h12, rw=1, bench slave drives 8'h5C on miso (updating after SCLK falls) -> MOSI = 0010010 1 00000000; rdata=8'h5C in the done cycle and held afterwards.
- Reset after the 5th SCLK rising edge -> cs=1 and sclk=0 at the next edge, busy=0, no further SCLK edges; a following write of addr=7'h01, wdata=8'hFF completes correctly.
- start pulsed while busy, then held high through done -> the mid-transaction start is ignored; the second frame's cs falls exactly 2 cycles after done; cs high for >= CLK_DIV cycles between frames.
- CLK_DIV=1, write addr=7'h7F, wdata=8'h00 -> SCLK period 2 clk; done at edge T+35; MOSI = 1111111 0 00000000.

Source files
------------

// File: rtl/spi_master_txn.sv
// SPI initiator: one framed transaction (addr + R/W command, then one data byte) per accepted start.
// Latency: done pulses 34*CLK_DIV cycles after the accepting edge; busy covers that whole window.
// Backpressure: start is only sampled while idle; requests during busy are dropped, never queued.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   start, rw, addr,  - host request; rw/addr/wdata are captured on the edge that accepts start
//   wdata
//   busy, done        - busy from the accepting edge through the done cycle; done is a 1-cycle pulse
//   rdata             - last completed read byte, held until the next read completes
//   sclk, cs, mosi    - SPI outputs (sclk idles low, cs active low), all registered
//   miso              - SPI input, sampled on the edge that ends each SCLK high phase
module spi_master_txn #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CMD_W   = ADDR_WIDTH + 1;
  localparam int FRAME_W = CMD_W + DATA_WIDTH;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST       = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST_DATA = BIT_W'(CMD_W);

  // Frame layout on the wire, MSB first: address, R/W flag, data byte.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic [DATA_WIDTH-1:0] data;
  } frameT;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    GAP,
    DONE
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [DIV_W-1:0]      divCnt;
  logic [BIT_W-1:0]      bitCnt;
  // Holds the frame bits still to be sent after the one currently on mosi.
  logic [FRAME_W-2:0]    txShift;
  logic [DATA_WIDTH-1:0] rxShift;
  logic                  rwLatched;

  frameT frameLoad;
  logic  phaseEnd;
  logic  lastBit;
  logic  csNext;
  logic  sclkNext;
  logic  busyNext;
  logic  doneNext;

  always_comb begin
    frameLoad.addr = addr;
    frameLoad.rw   = rw;
    // A read sends zeros in the data slot while the slave answers on miso.
    frameLoad.data = rw ? {DATA_WIDTH{1'b0}} : wdata;
  end

  assign phaseEnd = (divCnt == DIV_LAST);
  assign lastBit  = (bitCnt == BIT_LAST);

  // Next state plus the next value of every registered pin. The pins are
  // decoded from nextState so they change on the same edge as the state and
  // never pass through combinational glitches.
  always_comb begin
    nextState = state;
    csNext    = 1'b1;
    sclkNext  = 1'b0;
    busyNext  = 1'b1;
    doneNext  = 1'b0;

    case (state)
      IDLE:    if (start) nextState = LEAD;
      LEAD:    if (phaseEnd) nextState = HIGH;
      HIGH:    if (phaseEnd) nextState = LOW;
      LOW:     if (phaseEnd) nextState = lastBit ? GAP : HIGH;
      GAP:     if (phaseEnd) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase

    case (nextState)
      IDLE: busyNext = 1'b0;
      LEAD: csNext   = 1'b0;
      LOW:  csNext   = 1'b0;
      HIGH: begin
        csNext   = 1'b0;
        sclkNext = 1'b1;
      end
      DONE:    doneNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      divCnt    <= '0;
      bitCnt    <= '0;
      txShift   <= '0;
      rxShift   <= '0;
      rwLatched <= 1'b0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= nextState;
      cs    <= csNext;
      sclk  <= sclkNext;
      busy  <= busyNext;
      done  <= doneNext;

      // Half-period timer restarts at every phase change, so each phase
      // lasts exactly CLK_DIV cycles.
      if ((nextState != state) || (state == IDLE)) begin
        divCnt <= '0;
      end else begin
        divCnt <= divCnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            rwLatched <= rw;
            mosi      <= frameLoad[FRAME_W-1];
            txShift   <= frameLoad[FRAME_W-2:0];
            rxShift   <= '0;
            bitCnt    <= '0;
          end
        end
        HIGH: begin
          if (phaseEnd) begin
            // Falling SCLK edge: present the next bit and sample the slave.
            mosi    <= txShift[FRAME_W-2];
            txShift <= {txShift[FRAME_W-3:0], 1'b0};
            if (rwLatched && (bitCnt >= BIT_FIRST_DATA)) begin
              rxShift <= {rxShift[DATA_WIDTH-2:0], miso};
            end
          end
        end
        LOW: begin
          if (phaseEnd) begin
            if (lastBit) begin
              mosi <= 1'b0;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (phaseEnd && rwLatched) begin
            rdata <= rxShift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_txn.sv
// Bench for spi_master_txn: two instances (CLK_DIV=4 and CLK_DIV=1) share stimulus,
// a bench-side SPI slave answers reads, and a monitor decodes the pins against a
// scoreboard of expected frames pushed as each request is driven.
module tb_spi_master_txn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       miso = 1'b0;
  logic       sel = 1'b0;   // 0 selects the CLK_DIV=4 instance, 1 the CLK_DIV=1 instance
  logic       start4, start1;

  logic       busy4, done4, sclk4, cs4, mosi4;
  logic [7:0] rdata4;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rdata1;

  assign start4 = start & ~sel;
  assign start1 = start & sel;

  spi_master_txn #(.CLK_DIV(4), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u4 (
    .clk(clk), .reset(reset), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .sclk(sclk4), .cs(cs4), .mosi(mosi4),
    .miso(miso)
  );

  spi_master_txn #(.CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso)
  );

  logic       mBusy, mDone, mSclk, mCs, mMosi;
  logic [7:0] mRdata;
  int         curDiv;
  assign mBusy  = sel ? busy1  : busy4;
  assign mDone  = sel ? done1  : done4;
  assign mSclk  = sel ? sclk1  : sclk4;
  assign mCs    = sel ? cs1    : cs4;
  assign mMosi  = sel ? mosi1  : mosi4;
  assign mRdata = sel ? rdata1 : rdata4;
  assign curDiv = sel ? 1 : 4;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          rises;
    bit          abort;
  } expT;

  expT sbQ[$];
  expT popped;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + slave, sampled on the falling clk edge (outputs are registered on rising).
  logic       prevSclk = 1'b0;
  logic       prevCs   = 1'b1;
  logic       donePrev = 1'b0;
  logic [15:0] capFrame = '0;
  logic [7:0] slaveByte = '0;
  int         riseCnt = 0;
  int         fallCnt = 0;
  int         frameStart = 0;
  int         csRiseCyc = 0;
  int         lastDoneCyc = 0;
  int         stray = 0;
  int         csGlitch = 0;
  bit         b2bCheck = 1'b0;

  always @(negedge clk) begin
    if (donePrev === 1'b1) chk("donePulse", mDone, 0);

    if (mCs === 1'b0 && prevCs === 1'b1) begin
      frameStart = cyc;
      riseCnt    = 0;
      fallCnt    = 0;
      capFrame   = '0;
      miso       = 1'b0;
      chk("frameExpected", sbQ.size() > 0, 1);
      chk("busyAtAccept", mBusy, 1);
      if (b2bCheck) begin
        chk("b2bCsFallAfterDone", cyc - lastDoneCyc, 2);
        chk("b2bCsHigh", cyc - csRiseCyc, curDiv + 2);
        b2bCheck = 1'b0;
      end
    end

    if (mCs !== prevCs && mSclk === 1'b1) csGlitch++;

    if (mSclk === 1'b1 && prevSclk === 1'b0) begin
      if (mCs !== 1'b0) stray++;
      else begin
        riseCnt++;
        capFrame = {capFrame[14:0], mMosi};
      end
    end

    // Slave shifts its byte out after each falling edge from the 8th on.
    if (mSclk === 1'b0 && prevSclk === 1'b1 && mCs === 1'b0) begin
      fallCnt++;
      if (fallCnt >= 8 && fallCnt < 16) miso = slaveByte[15 - fallCnt];
    end

    if (mCs === 1'b1 && prevCs === 1'b0) begin
      csRiseCyc = cyc;
      if (sbQ.size() > 0) begin
        chk("sclkRiseCount", riseCnt, sbQ[0].rises);
        if (sbQ[0].abort) void'(sbQ.pop_front());
        else chk("mosiFrame", capFrame, sbQ[0].frame);
      end
    end

    if (mDone === 1'b1) begin
      lastDoneCyc = cyc;
      chk("doneExpected", sbQ.size() > 0, 1);
      if (sbQ.size() > 0) begin
        popped = sbQ.pop_front();
        // cyc+1 is the edge that samples done; the accepting edge is frameStart.
        chk("doneLatency", cyc + 1 - frameStart, 34 * curDiv + 1);
        chk("rdataAtDone", mRdata, popped.rdata);
        chk("busyAtDone", mBusy, 1);
      end
    end

    donePrev = mDone;
    prevSclk = mSclk;
    prevCs   = mCs;
  end

  logic [7:0] expRdata = '0;

  task automatic pushTxn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] sb, input bit abort);
    expT e;
    e.frame = {a, r, (r ? 8'h00 : wd)};
    if (r && !abort) expRdata = sb;
    e.rdata = expRdata;
    e.rises = abort ? 5 : 16;
    e.abort = abort;
    sbQ.push_back(e);
  endtask

  task automatic startTxn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                          input logic [7:0] sb, input bit abort);
    rw = r; addr = a; wdata = wd; slaveByte = sb;
    pushTxn(r, a, wd, sb, abort);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sbQ.size() != 0; i++) @(negedge clk);
    chk("drain", sbQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rstCs", cs4, 1);
    chk("rstSclk", sclk4, 0);
    chk("rstMosi", mosi4, 0);
    chk("rstBusy", busy4, 0);
    chk("rstDone", done4, 0);
    chk("rstRdata", rdata4, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Write with junk on miso: rdata must stay at its reset value.
    startTxn(1'b0, 7'h55, 8'hA3, 8'h3C, 1'b0);
    waitDrain(400);

    // Read: slave answers 5C.
    startTxn(1'b1, 7'h12, 8'h00, 8'h5C, 1'b0);
    waitDrain(400);
    repeat (10) @(negedge clk);
    chk("rdataHeld", rdata4, 8'h5C);

    // Reset after the 5th SCLK rising edge.
    startTxn(1'b1, 7'h12, 8'h00, 8'hE7, 1'b1);
    for (int i = 0; i < 400 && riseCnt != 5; i++) @(posedge clk);
    chk("abortReached", riseCnt, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abortCs", cs4, 1);
    chk("abortSclk", sclk4, 0);
    chk("abortBusy", busy4, 0);
    expRdata = 8'h00;
    chk("abortRdata", rdata4, expRdata);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abortNoEdges", riseCnt, 5);
    chk("abortQueue", sbQ.size(), 0);
    startTxn(1'b0, 7'h01, 8'hFF, 8'h00, 1'b0);
    waitDrain(400);

    // Frame A, a start pulse while busy (dropped), then start held for frame B.
    startTxn(1'b0, 7'h2A, 8'h11, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    rw = 1'b1; addr = 7'h00; wdata = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    b2bCheck = 1'b1;
    rw = 1'b1; addr = 7'h33; wdata = 8'hEE; slaveByte = 8'h96;
    pushTxn(1'b1, 7'h33, 8'hEE, 8'h96, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 400 && b2bCheck; i++) @(negedge clk);
    start = 1'b0;
    chk("b2bAccepted", b2bCheck, 0);
    waitDrain(400);

    // CLK_DIV=1 instance: it has only ever been reset, so its rdata is 0.
    sel = 1'b1;
    expRdata = 8'h00;
    @(negedge clk);
    startTxn(1'b0, 7'h7F, 8'h00, 8'h00, 1'b0);
    waitDrain(200);

    chk("strayEdges", stray, 0);
    chk("csWhileSclkHigh", csGlitch, 0);
    chk("finalQueue", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
